// File: rtl/sweep_learn_ctrl.sv
// Learn-mode sweep initiator: steps the DDS through NUM_STEPS codes and stores peak-to-peak ADC amplitude per step.
// Optional macro SWEEP_TIMEOUT_EN enables the freq_code acknowledge timeout (sticky err plus abort).
module sweep_learn_ctrl #(
    parameter int NUM_STEPS    = 256,
    parameter int ADDR_W       = 8,
    parameter int START_CODE   = 4,
    parameter int SETTLE_CYC   = 50000,
    parameter int MEAS_SAMPLES = 1024,
    parameter int PULSE_LEN    = 4,
    parameter int ACK_TIMEOUT  = 1000
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       freq_code,
    input  logic [9:0]        adc_data,
    input  logic              adc_valid,
    output logic              learn_en,
    output logic              next_freq,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [10:0]       res_data
);

    localparam int CYC_W = $clog2(SETTLE_CYC + 1);
    localparam int SMP_W = $clog2(MEAS_SAMPLES + 1);
    localparam int PLS_W = $clog2(PULSE_LEN + 1);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ENTER, S_SETTLE, S_MEASURE, S_STORE,
        S_STEP, S_PULSE, S_WAIT, S_FINISH
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  step;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [SMP_W-1:0]   smp_cnt;
    logic [PLS_W-1:0]   pls_cnt;
    logic [ACK_W-1:0]   ack_cnt;
    logic [15:0]        cap_code;
    logic signed [9:0]  max_s;
    logic signed [9:0]  min_s;
    logic signed [9:0]  adc_s;
    logic [10:0]        p2p;

    // adc_valid qualifies adc_data for exactly one cycle; there is no back-pressure,
    // so every valid sample seen in MEASURE is consumed and all others are dropped.
    assign adc_s = adc_data;
    // Sign-extended difference; max >= min so the result always fits 0..1023.
    assign p2p = {max_s[9], max_s} - {min_s[9], min_s};

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            step      <= '0;
            cyc_cnt   <= '0;
            smp_cnt   <= '0;
            pls_cnt   <= '0;
            ack_cnt   <= '0;
            cap_code  <= '0;
            max_s     <= '0;
            min_s     <= '0;
            learn_en  <= 1'b0;
            next_freq <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
        end else begin
            res_we <= 1'b0;
            done   <= 1'b0;
            if (state != S_IDLE && abort) begin
                learn_en  <= 1'b0;
                next_freq <= 1'b0;
                busy      <= 1'b0;
                state     <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            learn_en <= 1'b1;
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            step     <= '0;
                            ack_cnt  <= '0;
                            state    <= S_ENTER;
                        end
                    end
                    S_ENTER: begin
                        if (freq_code == 16'(START_CODE)) begin
                            cyc_cnt <= '0;
                            state   <= S_SETTLE;
                        end
`ifdef SWEEP_TIMEOUT_EN
                        else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                            err      <= 1'b1;
                            learn_en <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
`endif
                        else if (ack_cnt != ACK_W'(ACK_TIMEOUT)) begin
                            ack_cnt <= ack_cnt + ACK_W'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (cyc_cnt == CYC_W'(SETTLE_CYC - 1)) begin
                            smp_cnt <= '0;
                            state   <= S_MEASURE;
                        end else begin
                            cyc_cnt <= cyc_cnt + CYC_W'(1);
                        end
                    end
                    S_MEASURE: begin
                        if (adc_valid) begin
                            if (smp_cnt == '0) begin
                                max_s <= adc_s;
                                min_s <= adc_s;
                            end else begin
                                if (adc_s > max_s) max_s <= adc_s;
                                if (adc_s < min_s) min_s <= adc_s;
                            end
                            if (smp_cnt == SMP_W'(MEAS_SAMPLES - 1)) begin
                                state <= S_STORE;
                            end else begin
                                smp_cnt <= smp_cnt + SMP_W'(1);
                            end
                        end
                    end
                    S_STORE: begin
                        res_we   <= 1'b1;
                        res_addr <= step;
                        res_data <= p2p;
                        if (step == ADDR_W'(NUM_STEPS - 1)) begin
                            state <= S_FINISH;
                        end else begin
                            step  <= step + ADDR_W'(1);
                            state <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        cap_code  <= freq_code;
                        next_freq <= 1'b1;
                        pls_cnt   <= '0;
                        state     <= S_PULSE;
                    end
                    S_PULSE: begin
                        // The controller double-flops next_freq, so the pulse is held PULSE_LEN cycles.
                        if (pls_cnt == PLS_W'(PULSE_LEN - 1)) begin
                            next_freq <= 1'b0;
                            ack_cnt   <= '0;
                            state     <= S_WAIT;
                        end else begin
                            pls_cnt <= pls_cnt + PLS_W'(1);
                        end
                    end
                    S_WAIT: begin
                        if (freq_code != cap_code) begin
                            cyc_cnt <= '0;
                            state   <= S_SETTLE;
                        end
`ifdef SWEEP_TIMEOUT_EN
                        else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                            err      <= 1'b1;
                            learn_en <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
`endif
                        else if (ack_cnt != ACK_W'(ACK_TIMEOUT)) begin
                            ack_cnt <= ack_cnt + ACK_W'(1);
                        end
                    end
                    S_FINISH: begin
                        learn_en <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/sweep_learn_ctrl.md
Name: sweep_learn_ctrl

Overview:
- Initiator side of the learn-mode interface (learn_en / next_freq) of the DDS frequency controller.
- Holds learn_en high and steps the DDS through NUM_STEPS consecutive frequency codes, one next_freq pulse per step.
- At each code: waits a settle time, measures the peak-to-peak amplitude of the returned ADC samples, and writes one result word per step into an external result RAM.
- Sits in the clk_50m domain next to the frequency controller and feeds the filter-learning results store.

Parameters:
- NUM_STEPS, 256: number of frequency points per sweep.
- ADDR_W, 8: result address width; must satisfy 2^ADDR_W >= NUM_STEPS.
- START_CODE, 4: frequency code the DDS loads on learn entry.
- SETTLE_CYC, 50000: clk_50m cycles waited after each frequency change before measuring.
- MEAS_SAMPLES, 1024: valid ADC samples per measurement.
- PULSE_LEN, 4: next_freq high time in cycles; minimum 2.
- ACK_TIMEOUT, 1000: cycles allowed for freq_code to react (used only with SWEEP_TIMEOUT_EN).

Ports:
- clk_50m  in  1  system clock.
- rst_n  in  1  reset.
- start  in  1  one-cycle sweep request.
- abort  in  1  one-cycle sweep cancel.
- freq_code  in  16  current DDS frequency code (freq*100), fed back from the controller.
- adc_data  in  10  signed ADC sample.
- adc_valid  in  1  adc_data qualifier, at most one per cycle.
- learn_en  out  1  learn-mode request to the DDS controller.
- next_freq  out  1  step pulse to the DDS controller.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- err  out  1  sticky timeout flag.
- res_we  out  1  result write strobe.
- res_addr  out  ADDR_W  result address (step index).
- res_data  out  11  unsigned peak-to-peak amplitude.

Interface (already decided): one clock, clk_50m; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values: all outputs 0; state IDLE; step counter 0.
- IDLE:
  - start=1 -> ENTER. learn_en and busy are registered high in the same edge.
  - start while busy is ignored.
- ENTER:
  - Wait until freq_code==START_CODE, then clear the cycle counter -> SETTLE.
- SETTLE:
  - Count SETTLE_CYC cycles -> MEASURE.
  - adc_valid is ignored during SETTLE.
- MEASURE:
  - The first valid sample loads both max and min; later samples update max/min (signed compare).
  - After MEAS_SAMPLES valid samples -> STORE.
- STORE (one cycle):
  - res_we=1, res_addr=step, res_data=max-min computed at 11 bits (range 0..1023).
  - If step==NUM_STEPS-1 -> FINISH; otherwise step+1 -> STEP.
- STEP:
  - Capture freq_code, then drive next_freq high for exactly PULSE_LEN cycles. The controller synchronises through two flops, so pulses shorter than 2 cycles are illegal.
  - Then wait until freq_code differs from the captured value -> SETTLE.
- FINISH:
  - learn_en=0, busy=0, done pulses for 1 cycle -> IDLE.
  - The DDS restores its pre-learn frequency on its own.
- abort in any non-IDLE state:
  - Next edge: learn_en=0, next_freq=0, busy=0, -> IDLE.
  - done is not pulsed, no further res_we, err unchanged.
- start and abort in the same cycle in IDLE: abort wins, stay IDLE.
- err is cleared by start (when accepted) or by reset.
- Reset mid-sweep drops learn_en immediately (asynchronous); no result is written.

Optional Feature:
- Macro SWEEP_TIMEOUT_EN.
- Defined: in ENTER, and in STEP after the pulse, a counter runs. If freq_code has not reacted within ACK_TIMEOUT cycles: err=1 and the block behaves as abort (learn_en=0, IDLE, no done).
- Undefined: the block waits indefinitely and err stays 0 (port still present).

Test Plan:
- Reset with NUM_STEPS=4, SETTLE_CYC=8, MEAS_SAMPLES=4 -> all outputs 0.
- start; model sets freq_code=4 and increments it on each next_freq rising edge; ADC samples +100,-50,+20,-200 at each step -> four writes, addr 0..3, res_data 300 each. next_freq pulses exactly 3 times, each 4 cycles wide. done 1 cycle after the last write; learn_en low.
- adc_valid active during SETTLE with value 511, then MEASURE samples all 0 -> res_data 0 (settle samples discarded).
- Samples -512 then +511 -> res_data 1023 (no overflow).
- abort during step 2 MEASURE -> learn_en low next cycle; no further res_we; done never pulses; a new start then runs a full sweep from addr 0.
- With SWEEP_TIMEOUT_EN and ACK_TIMEOUT=20, model ignores next_freq -> err=1 at cycle 20 after the pulse ends, learn_en=0. Without the macro, the block remains in STEP with busy=1.
